// File: rtl/uart_frame_loader_if.sv
// Byte-stream input and clue-memory/status output bundle for uart_frame_loader.
interface uart_frame_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              axiiv;
  logic [7:0]        axiid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_done;
  logic              frame_err;
  logic [7:0]        frame_len;
  logic              mem_valid;

  modport slave (
    input  axiiv, axiid,
    output wr_en, wr_addr, wr_data, busy, frame_done, frame_err, frame_len, mem_valid
  );

  modport master (
    output axiiv, axiid,
    input  wr_en, wr_addr, wr_data, busy, frame_done, frame_err, frame_len, mem_valid
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Frames the UART byte stream (SOF, length, payload[, checksum]) into clue-memory writes.
// Define UART_FRAME_CHKSUM_EN to require a trailing XOR checksum byte per frame.
module uart_frame_loader #(
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 262144
) (
  input  logic                clk,
  input  logic                rst,
  uart_frame_loader_if.slave  bus
);

  localparam int unsigned      IDX_W     = ADDR_W + 1;
  localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LEN     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
`ifdef UART_FRAME_CHKSUM_EN
  localparam logic [1:0] CHK     = 2'd3;
`endif

  logic [1:0]        state,  state_nxt;
  logic [IDX_W-1:0]  index,  index_nxt;
  logic [IDX_W-1:0]  idx_inc;
  logic [7:0]        len,    len_nxt;
  logic [TMO_W-1:0]  tmo,    tmo_nxt;
`ifdef UART_FRAME_CHKSUM_EN
  logic [7:0]        chk,    chk_nxt;
`endif

  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;
  logic              done_nxt;
  logic              err_nxt;
  logic [7:0]        frame_len_nxt;
  logic              mem_valid_nxt;

  // Next-state and next-output decode; a byte in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nxt     = state;
    index_nxt     = index;
    len_nxt       = len;
    tmo_nxt       = tmo;
`ifdef UART_FRAME_CHKSUM_EN
    chk_nxt       = chk;
`endif
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = bus.wr_addr;
    wr_data_nxt   = bus.wr_data;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    frame_len_nxt = bus.frame_len;
    mem_valid_nxt = bus.mem_valid;
    idx_inc       = index + IDX_W'(1);

    if (state == IDLE) begin
      tmo_nxt = '0;
      if (bus.axiiv && (bus.axiid == SOF_BYTE)) begin
        state_nxt     = LEN;
        mem_valid_nxt = 1'b0;
      end
    end else if (!bus.axiiv) begin
      if (tmo == TMO_LAST) begin
        err_nxt   = 1'b1;
        state_nxt = IDLE;
        tmo_nxt   = '0;
      end else begin
        tmo_nxt = tmo + TMO_W'(1);
      end
    end else begin
      tmo_nxt = '0;
      case (state)
        LEN: begin
          if ((bus.axiid == 8'd0) || (bus.axiid > MAX_LEN_B)) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            len_nxt   = bus.axiid;
            index_nxt = '0;
`ifdef UART_FRAME_CHKSUM_EN
            chk_nxt   = bus.axiid;
`endif
            state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = index[ADDR_W-1:0];
          wr_data_nxt = bus.axiid;
          index_nxt   = idx_inc;
`ifdef UART_FRAME_CHKSUM_EN
          chk_nxt     = chk ^ bus.axiid;
          if (8'(idx_inc) == len) begin
            state_nxt = CHK;
          end
`else
          // Without a checksum the last payload byte completes the frame directly.
          if (8'(idx_inc) == len) begin
            done_nxt      = 1'b1;
            frame_len_nxt = len;
            mem_valid_nxt = 1'b1;
            state_nxt     = IDLE;
          end
`endif
        end
`ifdef UART_FRAME_CHKSUM_EN
        CHK: begin
          if (bus.axiid == chk) begin
            done_nxt      = 1'b1;
            frame_len_nxt = len;
            mem_valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end
`endif
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; reset drops any in-flight write without an error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      index          <= '0;
      len            <= '0;
      tmo            <= '0;
`ifdef UART_FRAME_CHKSUM_EN
      chk            <= '0;
`endif
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.frame_len  <= '0;
      bus.mem_valid  <= 1'b0;
    end else begin
      state          <= state_nxt;
      index          <= index_nxt;
      len            <= len_nxt;
      tmo            <= tmo_nxt;
`ifdef UART_FRAME_CHKSUM_EN
      chk            <= chk_nxt;
`endif
      bus.wr_en      <= wr_en_nxt;
      bus.wr_addr    <= wr_addr_nxt;
      bus.wr_data    <= wr_data_nxt;
      bus.busy       <= (state_nxt != IDLE);
      bus.frame_done <= done_nxt;
      bus.frame_err  <= err_nxt;
      bus.frame_len  <= frame_len_nxt;
      bus.mem_valid  <= mem_valid_nxt;
    end
  end

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
Controller that sequences the byte stream from the UART receiver into framed puzzle-clue loads. It sits between the receiver's byte output (valid pulse plus 8-bit data) and the clue memory. It hunts for a start-of-frame byte, reads a length byte, writes the payload bytes to sequential memory addresses, checks an XOR checksum, and reports frame completion or error to the solver control.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame marker.
MAX_LEN, 64, maximum payload bytes per frame (1..255).
ADDR_W, 6, clue memory address width; must satisfy 2**ADDR_W >= MAX_LEN.
TIMEOUT_CYCLES, 262144, max idle clk cycles between bytes inside a frame (about 2.5 byte times at 9600 baud, 100 MHz).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-low reset.
axiiv  input  1  byte-valid pulse from the UART receiver (1 cycle per byte).
axiid  input  8  received byte; sampled only when axiiv=1.
wr_en  output  1  clue memory write strobe.
wr_addr  output  ADDR_W  clue memory write address.
wr_data  output  8  clue memory write data.
busy  output  1  high while a frame is in progress (state != IDLE).
frame_done  output  1  one-cycle pulse: frame accepted.
frame_err  output  1  one-cycle pulse: frame rejected.
frame_len  output  8  length of the last accepted frame; holds until the next accepted frame.
mem_valid  output  1  high after an accepted frame; cleared when a new SOF is accepted.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. All outputs 0: wr_en, wr_addr, wr_data, busy, frame_done, frame_err, frame_len, mem_valid. Timeout counter 0, checksum 0.
- All outputs are registered. The response to a byte accepted at edge N is visible after edge N+1.
- States: IDLE, LEN, PAYLOAD, CHK.
- IDLE: a byte equal to SOF_BYTE -> LEN, clear mem_valid. Any other byte is ignored silently, with no error.
- LEN:
  - Byte L with 1 <= L <= MAX_LEN -> latch L, set checksum=L, set index=0, go to PAYLOAD.
  - L=0 or L>MAX_LEN -> frame_err pulse, go to IDLE.
- PAYLOAD: each byte is written with wr_en=1 for exactly one cycle, wr_addr=index, wr_data=byte.
  - checksum ^= byte; index increments.
  - After the L-th byte -> CHK.
  - Writes are never held back; there is no backpressure.
- CHK:
  - Byte == checksum -> frame_done pulse, frame_len=L, mem_valid=1, go to IDLE.
  - Otherwise -> frame_err pulse, go to IDLE. mem_valid stays 0.
  - Memory contents from a rejected frame are not valid; the consumer must gate on mem_valid.
- Timeout:
  - Counter resets to 0 on every accepted byte and runs only while busy.
  - Reaching TIMEOUT_CYCLES-1 with no byte -> frame_err pulse, go to IDLE.
  - A byte arriving in the same cycle as expiry wins: it is processed and the counter resets.
- A SOF_BYTE value inside LEN, PAYLOAD or CHK is treated as ordinary data, not a resync.
- frame_done and frame_err are mutually exclusive and never assert in consecutive cycles for the same frame.
- busy = (state != IDLE), registered with the state.
- Reset mid-frame: returns to IDLE within one edge. Any in-flight wr_en is dropped, no error pulse is issued, mem_valid=0.
- Widths: index is ADDR_W+1 bits so that index=MAX_LEN is representable. The timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates; it never wraps.

Optional Feature:
UART_FRAME_CHKSUM_EN.
- Defined: CHK state present, behaving as above.
- Undefined: no CHK state and no checksum byte on the wire. After the L-th payload byte the next edge pulses frame_done, sets frame_len=L and mem_valid=1, and returns to IDLE. Checksum logic is removed. Length errors and timeout errors are unchanged.

Test Plan:
1. Reset held for 2 cycles, then released, idle 100 cycles -> all outputs 0, busy=0.
2. Good frame (CHKSUM_EN defined): bytes A5, 03, 11, 22, 33, 03^11^22^33=03 -> writes (0,11), (1,22), (2,33) each 1 cycle after its byte; frame_done 1 cycle after the last byte; frame_len=3; mem_valid=1.
3. Bad checksum: bytes A5, 02, 0F, F0, 00 (correct value 02^0F^F0=FD) -> 2 writes, then frame_err pulse, mem_valid=0, busy=0.
4. Length errors: A5, 00 -> frame_err. A5, 41 with MAX_LEN=64 -> frame_err, no wr_en. Stray bytes 12, 34 in IDLE -> no pulses, busy=0.
5. Timeout: A5, 02, 55, then silence -> frame_err exactly TIMEOUT_CYCLES cycles after the byte 55. Repeat with a byte landing on the expiry cycle -> no error, frame continues.
6. Reset asserted after the 2nd payload byte of a 4-byte frame -> next cycle busy=0, mem_valid=0, no frame_err. A following good frame is accepted normally.
